imem_loader: RTL and testbench

- Writable instruction memory for the single-cycle Yu Core.
- Receives a little-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them sequentially from word 0.
- Gives the core a combinational, 4-byte-aligned read port.
- Asserts load_busy while loading; the top level holds the core in stall/reset on it.

---
 rtl/yu_loader_pkg.sv | 14 +
 rtl/byte_word_packer.sv | 50 +++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yu_loader_pkg.sv
// Shared types and constants for the Yu Core instruction-memory loader.
package yu_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_WIDTH = 2;

endpackage : yu_loader_pkg

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid_o pulses in the cycle the 4th byte of a word is accepted;
// word_o holds the complete word from the following cycle until the next byte.
module byte_word_packer
   import yu_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        byte_fire_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam logic [BYTE_IDX_WIDTH-1:0] LAST_IDX = BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1);

   logic [BYTE_IDX_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]               word_q, word_d;

   // Next-state: shift each new byte in from the top so byte k ends up in bits [8k+7:8k].
   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
      idx_d  = idx_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d  = '0;
         word_d = '0;
      end else if (byte_fire_i) begin
         idx_d  = idx_q + BYTE_IDX_WIDTH'(1);
         word_d = {byte_i, word_q[31:8]};
      end
   end

   // Byte index and shift register state.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   assign word_valid_o = byte_fire_i && (idx_q == LAST_IDX);
   assign word_o       = word_q;

endmodule : byte_word_packer

// File: rtl/imem_loader.sv
// Writable instruction memory for the single-cycle Yu Core.
// Loads words from a valid/ready byte stream starting at word 0 and serves a
// combinational, word-aligned read port to the core.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add load_checksum, the
// modulo-2^32 sum of the words written by the current load.
module imem_loader
   import yu_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE   = 64,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic [LEN_WIDTH-1:0]  load_len,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  load_error,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]           load_checksum
`endif
);

   localparam int IDX_W = $clog2(MEM_SIZE);
   localparam int PTR_W = IDX_W + 1;

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   loader_state_t     state_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  len_q;
   logic              byte_ready_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;

   logic              byte_fire;
   logic              start_ok;
   logic              word_valid;
   logic [31:0]       word;
   logic [PTR_W-1:0]  ptr_next;
   logic              unused_addr;

   assign byte_fire = byte_valid && byte_ready_q;
   assign start_ok  = load_start && (state_q == IDLE || state_q == DONE);
   assign ptr_next  = ptr_q + PTR_W'(1);

   byte_word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (start_ok),
      .byte_fire_i  (byte_fire),
      .byte_i       (byte_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // Load FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         len_q        <= '0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_ok) begin
                  if (load_len == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     error_q <= 1'b0;
                  end else if (load_len > LEN_WIDTH'(MEM_SIZE)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                  end else begin
                     state_q      <= RECV;
                     ptr_q        <= '0;
                     len_q        <= load_len[PTR_W-1:0];
                     byte_ready_q <= 1'b1;
                     busy_q       <= 1'b1;
                     done_q       <= 1'b0;
                     error_q      <= 1'b0;
                  end
               end
            end
            RECV: begin
               if (word_valid) begin
                  state_q      <= WRITE;
                  byte_ready_q <= 1'b0;
               end
            end
            WRITE: begin
               ptr_q <= ptr_next;
               if (ptr_next == len_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q      <= RECV;
                  byte_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= IDLE;
               byte_ready_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   // Memory write port: one word per WRITE cycle.
   // NOTE: the array has no reset; its contents survive rst_n and start undefined.
   always_ff @(posedge clk) begin
      if (state_q == WRITE) begin
         mem[ptr_q[IDX_W-1:0]] <= word;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum_q;

   // Running sum of the words written by the current load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum_q <= '0;
      end else if (start_ok) begin
         checksum_q <= '0;
      end else if (state_q == WRITE) begin
         checksum_q <= checksum_q + word;
      end
   end

   assign load_checksum = checksum_q;
`endif

   // Core fetch port: byte offset within the word is ignored.
   assign data        = mem[address[IDX_W+1:2]];
   assign unused_addr = ^{address[ADDR_WIDTH-1:IDX_W+2], address[1:0]};

   assign byte_ready = byte_ready_q;
   assign load_busy  = busy_q;
   assign load_done  = done_q;
   assign load_error = error_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (MEM_SIZE = 64).
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start;
   logic [15:0] load_len;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        load_busy;
   logic        load_done;
   logic        load_error;
   logic [31:0] address;
   logic [31:0] data;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] load_checksum;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc;
   logic [31:0] rd;

   imem_loader #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_SIZE   (64),
      .LEN_WIDTH  (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (load_start),
      .load_len      (load_len),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .load_busy     (load_busy),
      .load_done     (load_done),
      .load_error    (load_error),
      .address       (address),
      .data          (data)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .load_checksum (load_checksum)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Combinational read through the core port.
   task automatic read_word(input logic [31:0] addr, output logic [31:0] val);
      address = addr;
      #1;
      val = data;
   endtask

   // Present one byte from a falling edge and return on the falling edge after it was taken.
   task automatic send_byte(input logic [7:0] b);
      int n;
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("byte_ready_timeout", {31'b0, byte_ready}, 32'd1);
      @(negedge clk);
   endtask

   // Pulse load_start for one rising edge; returns on the falling edge after it was sampled.
   task automatic start_load(input logic [15:0] len);
      @(negedge clk);
      load_start = 1'b1;
      load_len   = len;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   // Count rising edges until load_done is seen, with a bound.
   task automatic wait_done(output int n);
      n = 0;
      while (!load_done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) check("load_done_timeout", {31'b0, load_done}, 32'd1);
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      load_start = 1'b0;
      load_len   = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      address    = '0;
      #12;
      check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
      check("rst_load_busy",  {31'b0, load_busy},  32'd0);
      check("rst_load_done",  {31'b0, load_done},  32'd0);
      check("rst_load_error", {31'b0, load_error}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq8 [8];
      logic [7:0] seq4 [4];

      // Two-word load with byte_valid held high.
      apply_reset();
      start_load(16'd2);
      seq8 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      fork
         begin
            for (int i = 0; i < 8; i++) send_byte(seq8[i]);
            byte_valid = 1'b0;
         end
         wait_done(cyc);
      join
      check("t1_done_latency", cyc, 32'd10);
      check("t1_done",  {31'b0, load_done},  32'd1);
      check("t1_busy",  {31'b0, load_busy},  32'd0);
      check("t1_error", {31'b0, load_error}, 32'd0);
      check("t1_ready", {31'b0, byte_ready}, 32'd0);
      read_word(32'h0, rd); check("t1_mem0",       rd, 32'h12345678);
      read_word(32'h4, rd); check("t1_mem1",       rd, 32'hDEADBEEF);
      read_word(32'h7, rd); check("t1_mem1_unal",  rd, 32'hDEADBEEF);

      // One-word load with byte_valid toggling; junk on idle cycles must not be taken.
      start_load(16'd1);
      check("t2_busy_start", {31'b0, load_busy}, 32'd1);
      seq4 = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
      for (int i = 0; i < 4; i++) begin
         send_byte(seq4[i]);
         if (i == 3) begin
            check("t2_ready_in_write", {31'b0, byte_ready}, 32'd0);
            check("t2_busy_in_write",  {31'b0, load_busy},  32'd1);
         end
         byte_valid = 1'b0;
         byte_data  = 8'hAA;
         @(negedge clk);
      end
      check("t2_done", {31'b0, load_done}, 32'd1);
      check("t2_busy", {31'b0, load_busy}, 32'd0);
      read_word(32'h0, rd); check("t2_mem0", rd, 32'hCAFEF00D);
      read_word(32'h4, rd); check("t2_mem1", rd, 32'hDEADBEEF);

      // Zero length and oversize length.
      apply_reset();
      start_load(16'd0);
      check("t3_zero_done",  {31'b0, load_done},  32'd1);
      check("t3_zero_busy",  {31'b0, load_busy},  32'd0);
      check("t3_zero_ready", {31'b0, byte_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_zero_busy_hold", {31'b0, load_busy}, 32'd0);
      end
      start_load(16'd65);
      check("t3_big_error", {31'b0, load_error}, 32'd1);
      check("t3_big_done",  {31'b0, load_done},  32'd1);
      check("t3_big_busy",  {31'b0, load_busy},  32'd0);
      read_word(32'h0, rd); check("t3_mem0", rd, 32'hCAFEF00D);
      read_word(32'h4, rd); check("t3_mem1", rd, 32'hDEADBEEF);

      // Reset after five bytes of a three-word load.
      start_load(16'd3);
      check("t4_busy",  {31'b0, load_busy},  32'd1);
      check("t4_error", {31'b0, load_error}, 32'd0);
      check("t4_done",  {31'b0, load_done},  32'd0);
      seq8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 5; i++) send_byte(seq8[i]);
      byte_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_rst_busy",  {31'b0, load_busy},  32'd0);
      check("t4_rst_ready", {31'b0, byte_ready}, 32'd0);
      check("t4_rst_done",  {31'b0, load_done},  32'd0);
      read_word(32'h0, rd); check("t4_mem0_kept", rd, 32'h44332211);
      read_word(32'h4, rd); check("t4_mem1_kept", rd, 32'hDEADBEEF);
      @(negedge clk);
      rst_n = 1'b1;
      start_load(16'd1);
      seq4 = '{8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 4; i++) send_byte(seq4[i]);
      byte_valid = 1'b0;
      wait_done(cyc);
      read_word(32'h0, rd); check("t4_reload_mem0", rd, 32'h04030201);

      // load_start during a load is ignored.
      start_load(16'd2);
      seq8 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h10, 8'h20, 8'h30, 8'h40};
      send_byte(seq8[0]);
      send_byte(seq8[1]);
      byte_valid = 1'b0;
      load_start = 1'b1;
      load_len   = 16'd1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 2; i < 8; i++) send_byte(seq8[i]);
      byte_valid = 1'b0;
      wait_done(cyc);
      check("t5_done", {31'b0, load_done}, 32'd1);
      read_word(32'h0, rd); check("t5_mem0", rd, 32'hD4C3B2A1);
      read_word(32'h4, rd); check("t5_mem1", rd, 32'h40302010);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum wraps modulo 2^32.
      start_load(16'd2);
      check("t6_csum_clear", load_checksum, 32'h0);
      seq8 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 4; i++) send_byte(seq8[i]);
      @(negedge clk);
      check("t6_csum_first", load_checksum, 32'h1);
      for (int i = 4; i < 8; i++) send_byte(seq8[i]);
      byte_valid = 1'b0;
      wait_done(cyc);
      check("t6_csum_final", load_checksum, 32'h0);
      read_word(32'h4, rd); check("t6_mem1", rd, 32'hFFFFFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_imem_loader
